simon32_64_core: RTL



---
 rtl/simon32_64_core.sv | 101 ++++++++++
 1 files changed

// File: rtl/simon32_64_core.sv
// rtl/simon32_64_core.sv - iterative SIMON 32/64 encryption core, one round per clock
// Optional debug ports dbg_round/dbg_rkey are enabled by defining SIMON_DEBUG_EN.
module simon32_64_core #(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] plaintxt_in,
  input  logic [63:0] key_in,
  output logic        ready,
  output logic [31:0] cipher_out,
  output logic        valid
`ifdef SIMON_DEBUG_EN
  ,
  output logic [4:0]  dbg_round,
  output logic [15:0] dbg_rkey
`endif
);

  // z0 written with index 0 as the leftmost (MSB) bit
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [4:0]  LAST_ROUND = 5'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] x, y;
  logic [15:0] k0, k1, k2, k3;
  logic [4:0]  round;

  logic [15:0] f_x, x_next, y_next, t1, t2, k_new;
  logic [5:0]  z_idx;
  logic        z_bit;

  always_comb begin
    f_x    = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
    x_next = y ^ f_x ^ k0;
    y_next = x;
    t1     = {k3[2:0], k3[15:3]} ^ k1;
    t2     = t1 ^ {t1[0], t1[15:1]};
    z_idx  = 6'd61 - {1'b0, round};
    z_bit  = Z0[z_idx];
    k_new  = ~k0 ^ t2 ^ {15'd0, z_bit} ^ 16'h0003;
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      k0         <= '0;
      k1         <= '0;
      k2         <= '0;
      k3         <= '0;
      round      <= '0;
      cipher_out <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            x     <= plaintxt_in[31:16];
            y     <= plaintxt_in[15:0];
            k0    <= key_in[15:0];
            k1    <= key_in[31:16];
            k2    <= key_in[47:32];
            k3    <= key_in[63:48];
            round <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          x     <= x_next;
          y     <= y_next;
          k0    <= k1;
          k1    <= k2;
          k2    <= k3;
          k3    <= k_new;
          round <= round + 5'd1;
          // Ciphertext comes straight from this edge's round result
          if (round == LAST_ROUND) begin
            cipher_out <= {x_next, y_next};
            valid      <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIMON_DEBUG_EN
  assign dbg_round = round;
  assign dbg_rkey  = k0;
`endif

endmodule
